btb_update_controller: RTL and testbench
========================================

Name: btb_update_controller

Overview:
- Owns the BTB RAM write port. Sequences the full-array invalidation sweep after reset and on flush requests, and buffers and arbitrates taken-branch updates from the resolving stage.
- Sits between the branch-resolution stage and the BTB storage array.
- Drives a lookup-enable to the fetch side so that BTB hits are suppressed while the array is being invalidated.

Parameters:
- ENTRY_NUM, 256, number of BTB entries (power of two).
- INDEX_WIDTH, 8, log2(ENTRY_NUM).
- TAG_WIDTH, 20, tag field width.
- CONTENT_WIDTH, 12, target/content field width.
- QUEUE_DEPTH, 4, pending-update buffer depth (>=2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flushReq  in  1  request full BTB invalidation
- updValid  in  1  taken-branch update offered
- updIndex  in  INDEX_WIDTH  update index
- updTag  in  TAG_WIDTH  update tag
- updContent  in  CONTENT_WIDTH  update content
- updReady  out  1  update accepted when updValid&&updReady at clk edge
- wHold  in  1  RAM write port unavailable this cycle
- ramWEnable  out  1  RAM write enable (registered)
- ramWAddr  out  INDEX_WIDTH  RAM write index (registered)
- ramWData  out  1+TAG_WIDTH+CONTENT_WIDTH  {valid,tag,content} (registered)
- lookupEnable  out  1  BTB hits may be used (registered)

Behaviour:
- Single clock. Reset is synchronous and active-high. All state changes on posedge clk.
- Reset values:
  - state=SWEEP, sweepCnt=0, queue empty.
  - ramWEnable=0, ramWAddr=0, ramWData=0, lookupEnable=0.
- States:
  - SWEEP: invalidation in progress.
  - RUN: normal operation.
- SWEEP behaviour:
  - Each edge with !wHold registers ramWEnable=1, ramWAddr=sweepCnt, ramWData=0, and increments sweepCnt.
  - Edge with wHold: ramWEnable=0 and sweepCnt holds.
  - The edge that issues index ENTRY_NUM-1 also sets state=RUN, lookupEnable=1, sweepCnt=0.
  - With wHold=0 the sweep takes exactly ENTRY_NUM cycles.
  - updReady=0 throughout SWEEP.
- RUN behaviour:
  - updReady (combinational) = (state==RUN) && !flushReq && (count<QUEUE_DEPTH || matching index present).
  - Write issue each edge:
    - wHold=1: ramWEnable=0.
    - Else if queue non-empty: write head {1,tag,content}, pop.
    - Else if accepting an update: write the incoming update directly (bypass, 1-cycle latency).
    - Else: ramWEnable=0.
  - Accepted update not bypassed:
    - If an entry with equal index is queued, overwrite that entry's tag/content in place. Order and count are unchanged.
    - Otherwise push at tail.
  - Coalescing compares against entries remaining after this edge's pop. A match on the head being popped this edge is not a match.
  - Simultaneous push and pop in the same edge is legal. Count is unchanged.
- Flush:
  - flushReq=1 in RUN: the queue is discarded and the incoming update is dropped (updReady=0).
  - Next edge: state=SWEEP, sweepCnt=0, lookupEnable=0, ramWEnable=0.
  - flushReq during SWEEP restarts sweepCnt at 0 on the next edge.
- Reset:
  - rst mid-sweep or mid-RUN returns all state to reset values.
  - rst has priority over flushReq, updates and wHold.
- Width rules:
  - sweepCnt is INDEX_WIDTH+1 bits. Compare against ENTRY_NUM-1; no wrap past the last index.
  - Queue count is clog2(QUEUE_DEPTH+1) bits. Never exceeds QUEUE_DEPTH.
- Invariants:
  - At most one RAM write per cycle.
  - ramWData valid bit is 0 only for sweep writes.

Test Plan:
- Reset then idle (ENTRY_NUM=8, wHold=0) -> ramWEnable=1 for 8 consecutive cycles, ramWAddr 0..7, ramWData=0. Then lookupEnable=1 and updReady=1 on the 9th cycle.
- RUN, single update idx=5 tag=0x12345 content=0xABC, wHold=0 -> next cycle ramWEnable=1, ramWAddr=5, ramWData={1,0x12345,0xABC}. Queue stays empty.
- RUN, wHold=1 for 6 cycles while offering updates idx 1,2,3,4,5 -> the first four are accepted and updReady drops for idx 5. Release wHold -> writes 1,2,3,4 in order, then idx 5 accepted.
- Hold, push idx=3 content=0x111, then idx=3 content=0x222 -> count=1. After release, a single write with content 0x222.
- Two updates queued, flushReq pulse -> queue discarded, no update writes, lookupEnable=0, and a fresh sweep from index 0.
- rst asserted at sweep index 4 -> outputs return to reset values and the sweep restarts at 0 after release.

Source files
------------

// File: rtl/btb_update_controller.sv
`default_nettype none
// ============================================================================
// Module   : btb_update_controller
// Purpose  : Owns the BTB RAM write port. Runs the full-array invalidation
//            sweep after reset and on flush requests, and buffers, coalesces
//            and issues taken-branch updates coming from branch resolution.
// Ports    :
//   clk, rst            - clock, synchronous active-high reset
//   flushReq            - request a full BTB invalidation
//   updValid/updReady   - update handshake (accepted when both high at edge)
//   updIndex/updTag/
//   updContent          - update payload
//   wHold               - RAM write port unavailable this cycle
//   ramWEnable/ramWAddr/
//   ramWData            - registered RAM write port, data = {valid,tag,content}
//   lookupEnable        - registered; BTB hits are usable when high
// Revision : 1.0 - initial release
// ============================================================================
module btb_update_controller #(
    parameter int ENTRY_NUM     = 256,
    parameter int INDEX_WIDTH   = 8,
    parameter int TAG_WIDTH     = 20,
    parameter int CONTENT_WIDTH = 12,
    parameter int QUEUE_DEPTH   = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flushReq,
    input  logic                                 updValid,
    input  logic [INDEX_WIDTH-1:0]               updIndex,
    input  logic [TAG_WIDTH-1:0]                 updTag,
    input  logic [CONTENT_WIDTH-1:0]             updContent,
    output logic                                 updReady,
    input  logic                                 wHold,
    output logic                                 ramWEnable,
    output logic [INDEX_WIDTH-1:0]               ramWAddr,
    output logic [TAG_WIDTH+CONTENT_WIDTH:0]     ramWData,
    output logic                                 lookupEnable
);

    localparam int c_data_w = 1 + TAG_WIDTH + CONTENT_WIDTH;
    localparam int c_cnt_w  = $clog2(QUEUE_DEPTH + 1);
    localparam int c_swp_w  = INDEX_WIDTH + 1;

    localparam logic [c_swp_w-1:0] c_last_idx  = c_swp_w'(ENTRY_NUM - 1);
    localparam logic [c_swp_w-1:0] c_swp_one   = c_swp_w'(1);
    localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(QUEUE_DEPTH);

    typedef enum logic [0:0] {
        S_SWEEP = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                     r_state;
    logic [c_swp_w-1:0]         r_sweep_cnt;
    logic [c_cnt_w-1:0]         r_count;
    logic [INDEX_WIDTH-1:0]     r_q_idx     [QUEUE_DEPTH];
    logic [TAG_WIDTH-1:0]       r_q_tag     [QUEUE_DEPTH];
    logic [CONTENT_WIDTH-1:0]   r_q_content [QUEUE_DEPTH];
    logic                       r_wen;
    logic [INDEX_WIDTH-1:0]     r_waddr;
    logic [c_data_w-1:0]        r_wdata;
    logic                       r_lookup;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t                     w_state_d;
    logic [c_swp_w-1:0]         w_sweep_cnt_d;
    logic [c_cnt_w-1:0]         w_count_d;
    logic [INDEX_WIDTH-1:0]     w_q_idx_d     [QUEUE_DEPTH];
    logic [TAG_WIDTH-1:0]       w_q_tag_d     [QUEUE_DEPTH];
    logic [CONTENT_WIDTH-1:0]   w_q_content_d [QUEUE_DEPTH];
    logic                       w_wen_d;
    logic [INDEX_WIDTH-1:0]     w_waddr_d;
    logic [c_data_w-1:0]        w_wdata_d;
    logic                       w_lookup_d;

    // ------------------------------------------------------------------
    // Queue control
    // ------------------------------------------------------------------
    logic                       w_any_match;
    logic [QUEUE_DEPTH-1:0]     w_co_vec;
    logic                       w_co_hit;
    logic                       w_upd_ready;
    logic                       w_accept;
    logic                       w_pop;
    logic                       w_bypass;
    logic                       w_coalesce;
    logic                       w_push;
    logic [c_cnt_w-1:0]         w_tail;

    always_comb begin
        w_any_match = 1'b0;
        w_co_vec    = '0;

        // Readiness may rely on any queued entry with the same index: even if
        // the only match is the head being popped, that pop frees a slot.
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if ((c_cnt_w'(i) < r_count) && (r_q_idx[i] == updIndex)) begin
                w_any_match = 1'b1;
            end
        end

        w_upd_ready = (r_state == S_RUN) && !flushReq &&
                      ((r_count < c_depth) || w_any_match);
        w_accept    = updValid && w_upd_ready;

        w_pop       = (r_state == S_RUN) && !flushReq && !wHold &&
                      (r_count != '0);
        // Bypass only when nothing is queued, so ordering is preserved.
        w_bypass    = w_accept && !wHold && (r_count == '0);

        // Coalescing looks only at entries that survive this edge's pop.
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if ((c_cnt_w'(i) < r_count) && !(w_pop && (i == 0)) &&
                (r_q_idx[i] == updIndex)) begin
                w_co_vec[i] = 1'b1;
            end
        end
        w_co_hit   = |w_co_vec;
        w_coalesce = w_accept && !w_bypass && w_co_hit;
        w_push     = w_accept && !w_bypass && !w_co_hit;
        w_tail     = r_count - c_cnt_w'(w_pop);
    end

    assign updReady = w_upd_ready;

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d     = r_state;
        w_sweep_cnt_d = r_sweep_cnt;
        w_count_d     = r_count;
        w_wen_d       = 1'b0;
        w_waddr_d     = r_waddr;
        w_wdata_d     = r_wdata;
        w_lookup_d    = r_lookup;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            w_q_idx_d[i]     = r_q_idx[i];
            w_q_tag_d[i]     = r_q_tag[i];
            w_q_content_d[i] = r_q_content[i];
        end

        case (r_state)
            S_SWEEP: begin
                if (flushReq) begin
                    w_sweep_cnt_d = '0;
                end else if (!wHold) begin
                    w_wen_d   = 1'b1;
                    w_waddr_d = r_sweep_cnt[INDEX_WIDTH-1:0];
                    w_wdata_d = '0;
                    if (r_sweep_cnt == c_last_idx) begin
                        w_state_d     = S_RUN;
                        w_lookup_d    = 1'b1;
                        w_sweep_cnt_d = '0;
                    end else begin
                        w_sweep_cnt_d = r_sweep_cnt + c_swp_one;
                    end
                end
            end

            S_RUN: begin
                if (flushReq) begin
                    w_state_d     = S_SWEEP;
                    w_sweep_cnt_d = '0;
                    w_lookup_d    = 1'b0;
                    w_count_d     = '0;
                end else begin
                    if (w_pop) begin
                        w_wen_d   = 1'b1;
                        w_waddr_d = r_q_idx[0];
                        w_wdata_d = {1'b1, r_q_tag[0], r_q_content[0]};
                    end else if (w_bypass) begin
                        w_wen_d   = 1'b1;
                        w_waddr_d = updIndex;
                        w_wdata_d = {1'b1, updTag, updContent};
                    end

                    // Overwrite first, then shift, so an in-place update of a
                    // surviving entry moves down together with it.
                    if (w_coalesce) begin
                        for (int i = 0; i < QUEUE_DEPTH; i++) begin
                            if (w_co_vec[i]) begin
                                w_q_tag_d[i]     = updTag;
                                w_q_content_d[i] = updContent;
                            end
                        end
                    end

                    if (w_pop) begin
                        for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
                            w_q_idx_d[i]     = w_q_idx_d[i+1];
                            w_q_tag_d[i]     = w_q_tag_d[i+1];
                            w_q_content_d[i] = w_q_content_d[i+1];
                        end
                    end

                    if (w_push) begin
                        for (int i = 0; i < QUEUE_DEPTH; i++) begin
                            if (c_cnt_w'(i) == w_tail) begin
                                w_q_idx_d[i]     = updIndex;
                                w_q_tag_d[i]     = updTag;
                                w_q_content_d[i] = updContent;
                            end
                        end
                    end

                    w_count_d = r_count - c_cnt_w'(w_pop) + c_cnt_w'(w_push);
                end
            end

            default: begin
                w_state_d     = S_SWEEP;
                w_sweep_cnt_d = '0;
                w_count_d     = '0;
                w_lookup_d    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_SWEEP;
            r_sweep_cnt <= '0;
            r_count     <= '0;
            r_wen       <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_lookup    <= 1'b0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_q_idx[i]     <= '0;
                r_q_tag[i]     <= '0;
                r_q_content[i] <= '0;
            end
        end else begin
            r_state     <= w_state_d;
            r_sweep_cnt <= w_sweep_cnt_d;
            r_count     <= w_count_d;
            r_wen       <= w_wen_d;
            r_waddr     <= w_waddr_d;
            r_wdata     <= w_wdata_d;
            r_lookup    <= w_lookup_d;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_q_idx[i]     <= w_q_idx_d[i];
                r_q_tag[i]     <= w_q_tag_d[i];
                r_q_content[i] <= w_q_content_d[i];
            end
        end
    end

    assign ramWEnable   = r_wen;
    assign ramWAddr     = r_waddr;
    assign ramWData     = r_wdata;
    assign lookupEnable = r_lookup;

endmodule
`default_nettype wire

// File: tb/tb_btb_update_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_btb_update_controller
// Purpose  : Self-checking bench for btb_update_controller (8-entry BTB,
//            4-deep update queue). Table of per-cycle vectors plus
//            hand-written flush and mid-sweep reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btb_update_controller;

    logic        clk;
    logic        rst;
    logic        flushReq;
    logic        updValid;
    logic [2:0]  updIndex;
    logic [19:0] updTag;
    logic [11:0] updContent;
    logic        updReady;
    logic        wHold;
    logic        ramWEnable;
    logic [2:0]  ramWAddr;
    logic [32:0] ramWData;
    logic        lookupEnable;

    int total = 0;
    int bad   = 0;

    btb_update_controller #(
        .ENTRY_NUM     (8),
        .INDEX_WIDTH   (3),
        .TAG_WIDTH     (20),
        .CONTENT_WIDTH (12),
        .QUEUE_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flushReq     (flushReq),
        .updValid     (updValid),
        .updIndex     (updIndex),
        .updTag       (updTag),
        .updContent   (updContent),
        .updReady     (updReady),
        .wHold        (wHold),
        .ramWEnable   (ramWEnable),
        .ramWAddr     (ramWAddr),
        .ramWData     (ramWData),
        .lookupEnable (lookupEnable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r, f, v;
        logic [2:0]  idx;
        logic [19:0] tg;
        logic [11:0] ct;
        logic        h;
        logic        ck_rdy, e_rdy;
        logic        e_wen;
        logic [2:0]  e_addr;
        logic [32:0] e_data;
        logic        e_look;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [32:0] dw(input logic [19:0] t, input logic [11:0] c);
        return {1'b1, t, c};
    endfunction

    function automatic logic [19:0] tk(input int k);
        return 20'hA0000 + 20'(k);
    endfunction

    function automatic logic [11:0] ck(input int k);
        return 12'h100 + 12'(k);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check updReady before the edge, check
    // registered outputs just after the edge. Address/data are compared when
    // a write is expected and on reset.
    task automatic cyc(input logic r, input logic f, input logic v,
                       input logic [2:0] idx, input logic [19:0] tg,
                       input logic [11:0] ct, input logic h,
                       input logic ck_rdy, input logic e_rdy,
                       input logic e_wen, input logic [2:0] e_addr,
                       input logic [32:0] e_data, input logic e_look);
        rst = r; flushReq = f; updValid = v;
        updIndex = idx; updTag = tg; updContent = ct; wHold = h;
        #1;
        if (ck_rdy) chk("updReady", 64'(updReady), 64'(e_rdy));
        @(posedge clk);
        #1;
        chk("ramWEnable", 64'(ramWEnable), 64'(e_wen));
        if (e_wen || r) begin
            chk("ramWAddr", 64'(ramWAddr), 64'(e_addr));
            chk("ramWData", 64'(ramWData), 64'(e_data));
        end
        chk("lookupEnable", 64'(lookupEnable), 64'(e_look));
    endtask

    function automatic void add(input logic r, input logic f, input logic v,
                                input logic [2:0] idx, input logic [19:0] tg,
                                input logic [11:0] ct, input logic h,
                                input logic ck_rdy, input logic e_rdy,
                                input logic e_wen, input logic [2:0] e_addr,
                                input logic [32:0] e_data, input logic e_look);
        vec_t x;
        x.r = r; x.f = f; x.v = v; x.idx = idx; x.tg = tg; x.ct = ct; x.h = h;
        x.ck_rdy = ck_rdy; x.e_rdy = e_rdy; x.e_wen = e_wen;
        x.e_addr = e_addr; x.e_data = e_data; x.e_look = e_look;
        tbl.push_back(x);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flushReq = 1'b0; updValid = 1'b0;
        updIndex = '0; updTag = '0; updContent = '0; wHold = 1'b0;

        // ---------------- table: reset, sweep, update traffic ----------------
        add(1,0,0,0,0,0,0, 0,0, 0,0,0, 0);
        for (int a = 0; a < 8; a++) add(0,0,0,0,0,0,0, 1,0, 1,3'(a),0, a == 7);
        // bypass write
        add(0,0,1,5,20'h12345,12'hABC,0, 1,1, 1,5,dw(20'h12345,12'hABC), 1);
        add(0,0,0,0,0,0,0, 1,1, 0,0,0, 1);
        // hold while filling: four accepted, idx5 stalls
        for (int k = 1; k <= 4; k++) add(0,0,1,3'(k),tk(k),ck(k),1, 1,1, 0,0,0, 1);
        add(0,0,1,5,tk(5),ck(5),1, 1,0, 0,0,0, 1);
        add(0,0,1,5,tk(5),ck(5),1, 1,0, 0,0,0, 1);
        add(0,0,1,5,tk(5),ck(5),0, 1,0, 1,1,dw(tk(1),ck(1)), 1);
        add(0,0,1,5,tk(5),ck(5),0, 1,1, 1,2,dw(tk(2),ck(2)), 1);
        add(0,0,0,0,0,0,0, 1,1, 1,3,dw(tk(3),ck(3)), 1);
        add(0,0,0,0,0,0,0, 1,1, 1,4,dw(tk(4),ck(4)), 1);
        add(0,0,0,0,0,0,0, 1,1, 1,5,dw(tk(5),ck(5)), 1);
        add(0,0,0,0,0,0,0, 1,1, 0,0,0, 1);
        // coalesce same index while held: one write with latest content
        add(0,0,1,3,tk(3),12'h111,1, 1,1, 0,0,0, 1);
        add(0,0,1,3,tk(3),12'h222,1, 1,1, 0,0,0, 1);
        add(0,0,0,0,0,0,0, 1,1, 1,3,dw(tk(3),12'h222), 1);
        add(0,0,0,0,0,0,0, 1,1, 0,0,0, 1);
        // full queue: coalesce still accepted, new index refused;
        // a match only on the popped head pushes at tail
        for (int k = 0; k < 4; k++) add(0,0,1,3'(k),tk(k),ck(k),1, 1,1, 0,0,0, 1);
        add(0,0,1,2,tk(2),12'hEEE,1, 1,1, 0,0,0, 1);
        add(0,0,1,6,tk(6),ck(6),1, 1,0, 0,0,0, 1);
        add(0,0,1,0,20'hBBBBB,12'hFFF,0, 1,1, 1,0,dw(tk(0),ck(0)), 1);
        add(0,0,0,0,0,0,0, 1,1, 1,1,dw(tk(1),ck(1)), 1);
        add(0,0,0,0,0,0,0, 1,1, 1,2,dw(tk(2),12'hEEE), 1);
        add(0,0,0,0,0,0,0, 1,1, 1,3,dw(tk(3),ck(3)), 1);
        add(0,0,0,0,0,0,0, 1,1, 1,0,dw(20'hBBBBB,12'hFFF), 1);
        add(0,0,0,0,0,0,0, 1,1, 0,0,0, 1);

        foreach (tbl[n]) begin
            cyc(tbl[n].r, tbl[n].f, tbl[n].v, tbl[n].idx, tbl[n].tg, tbl[n].ct,
                tbl[n].h, tbl[n].ck_rdy, tbl[n].e_rdy, tbl[n].e_wen,
                tbl[n].e_addr, tbl[n].e_data, tbl[n].e_look);
        end

        // ---------------- flush with two queued updates ----------------
        cyc(0,0,1,6,tk(6),ck(6),1, 1,1, 0,0,0, 1);
        cyc(0,0,1,7,tk(7),ck(7),1, 1,1, 0,0,0, 1);
        cyc(0,1,1,1,tk(1),ck(1),0, 1,0, 0,0,0, 0);
        cyc(0,0,0,0,0,0,1, 1,0, 0,0,0, 0);            // hold during sweep
        for (int a = 0; a < 3; a++) cyc(0,0,0,0,0,0,0, 1,0, 1,3'(a),0, 0);
        cyc(0,1,0,0,0,0,0, 1,0, 0,0,0, 0);            // flush restarts sweep
        for (int a = 0; a < 8; a++) cyc(0,0,0,0,0,0,0, 1,0, 1,3'(a),0, a == 7);
        cyc(0,0,0,0,0,0,0, 1,1, 0,0,0, 1);            // no stale update writes
        cyc(0,0,0,0,0,0,0, 1,1, 0,0,0, 1);

        // ---------------- reset at sweep index 4 ----------------
        cyc(0,1,0,0,0,0,0, 1,0, 0,0,0, 0);            // enter sweep via flush
        for (int a = 0; a < 4; a++) cyc(0,0,0,0,0,0,0, 1,0, 1,3'(a),0, 0);
        cyc(1,1,1,2,tk(2),ck(2),0, 1,0, 0,0,0, 0);    // rst beats flush/update
        for (int a = 0; a < 8; a++) cyc(0,0,0,0,0,0,0, 1,0, 1,3'(a),0, a == 7);
        cyc(0,0,1,4,tk(4),ck(4),0, 1,1, 1,4,dw(tk(4),ck(4)), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
